// File: rtl/vproc_vregwr_arbiter.sv
// Round-robin, burst-locked arbiter for the single vector-register-file write port, with a registered write stage and a beat watchdog.
// Optional VPROC_WRARB_LSU_PRIO_EN: port 0 (LSU) takes absolute priority in IDLE without moving the round-robin pointer.
module vproc_vregwr_arbiter #(
   parameter int unsigned NUM_PORTS = 5,
   parameter int unsigned VREG_W    = 128,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic                          clk_i,
   input  logic                          async_rst_ni,
   input  logic [NUM_PORTS-1:0]          req_valid_i,
   output logic [NUM_PORTS-1:0]          req_ready_o,
   input  logic [NUM_PORTS*5-1:0]        req_addr_i,
   input  logic [NUM_PORTS*VREG_W-1:0]   req_data_i,
   input  logic [NUM_PORTS*VREG_W/8-1:0] req_be_i,
   input  logic [NUM_PORTS-1:0]          req_last_i,
   input  logic                          wr_stall_i,
   output logic                          vreg_wr_en_o,
   output logic [4:0]                    vreg_wr_addr_o,
   output logic [VREG_W-1:0]             vreg_wr_data_o,
   output logic [VREG_W/8-1:0]           vreg_wr_be_o,
   output logic [NUM_PORTS-1:0]          grant_o,
   output logic                          err_o
);

   localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam int unsigned BE_W  = VREG_W / 8;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   owner, owner_nxt, rr_ptr, rr_ptr_nxt, winner, sel, release_ptr;
   logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
   logic               found, accept, last_sel, rr_upd, err_nxt;
   logic [NUM_PORTS-1:0] ready, grant;

   logic [4:0]         addr_a [NUM_PORTS];
   logic [VREG_W-1:0]  data_a [NUM_PORTS];
   logic [BE_W-1:0]    be_a   [NUM_PORTS];

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
      assign addr_a[g] = req_addr_i[g*5 +: 5];
      assign data_a[g] = req_data_i[g*VREG_W +: VREG_W];
      assign be_a[g]   = req_be_i[g*BE_W +: BE_W];
   end

   // First valid port at or above rr_ptr, wrapping; LSU pre-empts the search when prioritised.
   always_comb begin
      int unsigned idx;
      logic [PTR_W-1:0] cand;
      idx    = 0;
      cand   = '0;
      found  = 1'b0;
      winner = '0;
`ifdef VPROC_WRARB_LSU_PRIO_EN
      if (req_valid_i[0]) begin
         found  = 1'b1;
         winner = '0;
      end
`endif
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx  = (32'(rr_ptr) + i) % NUM_PORTS;
         cand = PTR_W'(idx);
         if (!found && req_valid_i[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         err_o    <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
         err_o    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      rr_ptr_nxt   = rr_ptr;
      beat_cnt_nxt = beat_cnt;
      err_nxt      = 1'b0;
      release_ptr  = (sel == PTR_W'(NUM_PORTS - 1)) ? '0 : sel + PTR_W'(1);
      rr_upd       = 1'b1;
`ifdef VPROC_WRARB_LSU_PRIO_EN
      if (sel == '0) rr_upd = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               if (last_sel) begin
                  if (rr_upd) rr_ptr_nxt = release_ptr;
               end else begin
                  state_nxt    = LOCKED;
                  owner_nxt    = winner;
                  beat_cnt_nxt = CNT_W'(1);
               end
            end
         end
         LOCKED: begin
            if (accept) begin
               if (last_sel || (beat_cnt + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
                  state_nxt    = IDLE;
                  beat_cnt_nxt = '0;
                  err_nxt      = !last_sel;
                  if (rr_upd) rr_ptr_nxt = release_ptr;
               end else begin
                  beat_cnt_nxt = beat_cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ready/grant are gated by reset so they drop together with the registered outputs.
   always_comb begin
      ready = '0;
      grant = '0;
      if (async_rst_ni) begin
         case (state)
            IDLE: begin
               if (found && !wr_stall_i) begin
                  ready[winner] = 1'b1;
                  grant[winner] = 1'b1;
               end
            end
            LOCKED: begin
               grant[owner] = 1'b1;
               ready[owner] = req_valid_i[owner] & !wr_stall_i;
            end
            default: ;
         endcase
      end
   end

   assign sel         = (state == LOCKED) ? owner : winner;
   assign accept      = |ready;
   assign last_sel    = req_last_i[sel];
   assign req_ready_o = ready;
   assign grant_o     = grant;

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         vreg_wr_en_o   <= 1'b0;
         vreg_wr_addr_o <= '0;
         vreg_wr_data_o <= '0;
         vreg_wr_be_o   <= '0;
      end else begin
         vreg_wr_en_o <= accept;
         if (accept) begin
            vreg_wr_addr_o <= addr_a[sel];
            vreg_wr_data_o <= data_a[sel];
            vreg_wr_be_o   <= be_a[sel];
         end
      end
   end

endmodule
